// File: rtl/uart_bus_port.sv
// rtl/uart_bus_port.sv - memory-mapped 8N1 UART with 4-entry TX FIFO on the shared 64-bit bus
module uart_bus_port #(
  parameter logic [63:0] BASE_ADDR    = 64'hFF00,
  parameter int          CLKS_PER_BIT = 434
) (
  input  logic        clock,
  input  logic        reset_n,
  inout  wire  [63:0] data,
  input  logic [63:0] address,
  input  logic        read,
  input  logic        write,
  output logic        uart_txd,
  input  logic        uart_rxd
);

  localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] HALF_LAST = 16'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  // address decode: exactly three registers
  logic hit_tx, hit_status, hit_rx, addr_hit;
  assign hit_tx     = (address == BASE_ADDR);
  assign hit_status = (address == BASE_ADDR + 64'd1);
  assign hit_rx     = (address == BASE_ADDR + 64'd2);
  assign addr_hit   = hit_tx | hit_status | hit_rx;

  // only the low byte of the bus carries TX data
  logic unused_data_hi;
  assign unused_data_hi = ^data[63:8];

  logic read_q, write_q;
  logic wr_edge, rd_clear;
  assign wr_edge  = write & ~write_q & hit_tx;
  assign rd_clear = read & ~read_q & hit_rx;

  // strobe history for rising-edge detection
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      read_q  <= 1'b0;
      write_q <= 1'b0;
    end else begin
      read_q  <= read;
      write_q <= write;
    end
  end

  // ---------------- TX FIFO ----------------
  logic [7:0] fifo_mem [4];
  logic [1:0] wr_ptr, rd_ptr;
  logic [2:0] fifo_count;
  logic       fifo_full, fifo_empty, push, pop;
  state_t     tx_state;

  assign fifo_full  = (fifo_count == 3'd4);
  assign fifo_empty = (fifo_count == 3'd0);
  assign push       = wr_edge & ~fifo_full;
  assign pop        = (tx_state == S_IDLE) & ~fifo_empty;

  // FIFO storage; contents are don't-care until pushed
  always_ff @(posedge clock) begin
    if (push) fifo_mem[wr_ptr] <= data[7:0];
  end

  // FIFO pointers and occupancy; push+pop together leaves count unchanged
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr     <= 2'd0;
      rd_ptr     <= 2'd0;
      fifo_count <= 3'd0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 2'd1;
      if (pop)  rd_ptr <= rd_ptr + 2'd1;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 3'd1;
        2'b01:   fifo_count <= fifo_count - 3'd1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // ---------------- TX shifter ----------------
  logic [15:0] tx_cnt;
  logic [7:0]  tx_shift;
  logic [2:0]  tx_bit;

  // TX FSM: start, 8 data bits LSB first, stop; each CLKS_PER_BIT long
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      tx_state <= S_IDLE;
      tx_cnt   <= 16'd0;
      tx_shift <= 8'd0;
      tx_bit   <= 3'd0;
      uart_txd <= 1'b1;
    end else begin
      case (tx_state)
        S_IDLE: begin
          uart_txd <= 1'b1;
          if (!fifo_empty) begin
            tx_shift <= fifo_mem[rd_ptr];
            tx_cnt   <= BIT_LAST;
            uart_txd <= 1'b0;
            tx_state <= S_START;
          end
        end
        S_START: begin
          if (tx_cnt != 16'd0) begin
            tx_cnt <= tx_cnt - 16'd1;
          end else begin
            tx_cnt   <= BIT_LAST;
            tx_bit   <= 3'd0;
            uart_txd <= tx_shift[0];
            tx_state <= S_DATA;
          end
        end
        S_DATA: begin
          if (tx_cnt != 16'd0) begin
            tx_cnt <= tx_cnt - 16'd1;
          end else begin
            tx_cnt <= BIT_LAST;
            if (tx_bit == 3'd7) begin
              uart_txd <= 1'b1;
              tx_state <= S_STOP;
            end else begin
              tx_bit   <= tx_bit + 3'd1;
              tx_shift <= {1'b0, tx_shift[7:1]};
              uart_txd <= tx_shift[1];
            end
          end
        end
        S_STOP: begin
          if (tx_cnt != 16'd0) tx_cnt <= tx_cnt - 16'd1;
          else                 tx_state <= S_IDLE;
        end
        default: tx_state <= S_IDLE;
      endcase
    end
  end

  logic tx_busy;
  assign tx_busy = (tx_state != S_IDLE) | ~fifo_empty;

  // ---------------- RX path ----------------
  logic rxd_meta, rxd_sync;

  // two-flop synchroniser for the asynchronous serial input, idles high
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rxd_meta <= 1'b1;
      rxd_sync <= 1'b1;
    end else begin
      rxd_meta <= uart_rxd;
      rxd_sync <= rxd_meta;
    end
  end

  state_t      rx_state;
  logic [15:0] rx_cnt;
  logic [7:0]  rx_shift;
  logic [2:0]  rx_bit;
  logic [7:0]  rx_byte;
  logic        rx_valid, rx_overrun;

  // RX FSM plus holding register; a byte landing on the RXDATA read edge wins over the clear
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rx_state   <= S_IDLE;
      rx_cnt     <= 16'd0;
      rx_shift   <= 8'd0;
      rx_bit     <= 3'd0;
      rx_byte    <= 8'd0;
      rx_valid   <= 1'b0;
      rx_overrun <= 1'b0;
    end else begin
      if (rd_clear) begin
        rx_valid   <= 1'b0;
        rx_overrun <= 1'b0;
      end
      case (rx_state)
        S_IDLE: begin
          if (!rxd_sync) begin
            rx_cnt   <= HALF_LAST;
            rx_state <= S_START;
          end
        end
        S_START: begin
          if (rx_cnt != 16'd0) begin
            rx_cnt <= rx_cnt - 16'd1;
          end else if (rxd_sync) begin
            rx_state <= S_IDLE;
          end else begin
            rx_cnt   <= BIT_LAST;
            rx_bit   <= 3'd0;
            rx_state <= S_DATA;
          end
        end
        S_DATA: begin
          if (rx_cnt != 16'd0) begin
            rx_cnt <= rx_cnt - 16'd1;
          end else begin
            rx_cnt   <= BIT_LAST;
            rx_shift <= {rxd_sync, rx_shift[7:1]};
            if (rx_bit == 3'd7) rx_state <= S_STOP;
            else                rx_bit   <= rx_bit + 3'd1;
          end
        end
        S_STOP: begin
          if (rx_cnt != 16'd0) begin
            rx_cnt <= rx_cnt - 16'd1;
          end else begin
            rx_state <= S_IDLE;
            if (rxd_sync) begin
              rx_byte    <= rx_shift;
              rx_valid   <= 1'b1;
              rx_overrun <= rx_valid & ~rd_clear;
            end
          end
        end
        default: rx_state <= S_IDLE;
      endcase
    end
  end

  // ---------------- read mux ----------------
  logic [63:0] rdata;

  // register read data from registered state
  always_comb begin
    rdata = 64'd0;
    if (hit_status)  rdata[3:0] = {rx_overrun, rx_valid, fifo_full, tx_busy};
    else if (hit_rx) rdata[7:0] = rx_byte;
  end

  assign data = (reset_n && read && addr_hit) ? rdata : 64'bz;

endmodule

// File: tb/tb_uart_bus_port.sv
// tb/tb_uart_bus_port.sv - randomized self-checking bench for uart_bus_port
`timescale 1ns/1ps
module tb_uart_bus_port;

  localparam logic [63:0] BASE     = 64'hFF00;
  localparam int          CPB      = 16;
  localparam logic [63:0] RELEASED = {64{1'b1}};

  logic        clock   = 1'b0;
  logic        reset_n = 1'b0;
  logic        read    = 1'b0;
  logic        write   = 1'b0;
  logic        loop_en = 1'b0;
  logic        rxd_drv = 1'b1;
  logic        tb_drv  = 1'b0;
  logic [63:0] address  = 64'd0;
  logic [63:0] tb_wdata = 64'd0;
  wire  [63:0] data;
  wire         uart_txd;
  wire         uart_rxd;

  int tests = 0;
  int fails = 0;

  assign data     = tb_drv ? tb_wdata : 64'bz;
  assign uart_rxd = loop_en ? uart_txd : rxd_drv;

  // a released bus floats up to all ones
  for (genvar i = 0; i < 64; i++) begin : g_pull
    pullup (data[i]);
  end

  uart_bus_port #(.BASE_ADDR(BASE), .CLKS_PER_BIT(CPB)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .data    (data),
    .address (address),
    .read    (read),
    .write   (write),
    .uart_txd(uart_txd),
    .uart_rxd(uart_rxd)
  );

  always #5 clock = ~clock;

  // serial line monitor: decodes every frame seen on uart_txd
  logic [7:0] mon_bytes[$];
  time        mon_start[$];
  initial begin : monitor
    logic [7:0] b;
    time        t;
    forever begin
      @(negedge uart_txd);
      t = $time;
      repeat (CPB / 2) @(negedge clock);
      for (int i = 0; i < 8; i++) begin
        repeat (CPB) @(negedge clock);
        b[i] = uart_txd;
      end
      repeat (CPB) @(negedge clock);
      if (uart_txd === 1'b1) begin
        mon_bytes.push_back(b);
        mon_start.push_back(t);
      end
    end
  end

  // behavioural receive-side model
  logic       m_valid = 1'b0;
  logic       m_ovr   = 1'b0;
  logic [7:0] m_byte  = 8'd0;

  function automatic void model_frame(input logic [7:0] b, input logic stop_ok);
    if (stop_ok) begin
      if (m_valid) m_ovr = 1'b1;
      else         m_valid = 1'b1;
      m_byte = b;
    end
  endfunction

  function automatic void model_read_rx();
    m_valid = 1'b0;
    m_ovr   = 1'b0;
  endfunction

  function automatic logic [63:0] model_status(input logic busy, input logic full);
    return {60'd0, m_ovr, m_valid, full, busy};
  endfunction

  task automatic bus_write(input logic [63:0] a, input logic [7:0] d);
    @(negedge clock);
    address  = a;
    tb_wdata = {56'd0, d};
    tb_drv   = 1'b1;
    write    = 1'b1;
    @(negedge clock);
    write  = 1'b0;
    tb_drv = 1'b0;
  endtask

  task automatic bus_read(input logic [63:0] a, output logic [63:0] v);
    @(negedge clock);
    address = a;
    read    = 1'b1;
    #1 v = data;
    @(negedge clock);
    read = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    logic [9:0] bits;
    bits = {stop_bit, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rxd_drv = bits[i];
      repeat (CPB) @(negedge clock);
    end
    rxd_drv = 1'b1;
    repeat (CPB) @(negedge clock);
  endtask

  task automatic test_reset();
    logic [63:0] v;
    reset_n = 1'b0;
    address = BASE + 64'd1;
    read    = 1'b1;
    repeat (3) @(negedge clock);
    tests++;
    if (data !== RELEASED) begin fails++; $display("FAIL reset_bus: got %h expected %h", data, RELEASED); end
    tests++;
    if (uart_txd !== 1'b1) begin fails++; $display("FAIL reset_txd: got %b expected 1", uart_txd); end
    read = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    bus_read(BASE + 64'd1, v);
    tests++;
    if (v !== 64'd0) begin fails++; $display("FAIL reset_status: got %h expected 0", v); end
    bus_read(BASE + 64'd2, v);
    tests++;
    if (v !== 64'd0) begin fails++; $display("FAIL reset_rxdata: got %h expected 0", v); end
    bus_read(BASE + 64'd3, v);
    tests++;
    if (v !== RELEASED) begin fails++; $display("FAIL decode_above: got %h expected %h", v, RELEASED); end
    bus_read(BASE - 64'd1, v);
    tests++;
    if (v !== RELEASED) begin fails++; $display("FAIL decode_below: got %h expected %h", v, RELEASED); end
  endtask

  task automatic test_single_tx(input logic [7:0] b);
    logic [9:0]  fb;
    logic [9:0]  bad;
    logic [63:0] v, vmid;
    int          w;
    fb  = {1'b1, b, 1'b0};
    bad = '0;
    bus_write(BASE, b);
    w = 0;
    while (uart_txd !== 1'b0 && w < 4) begin
      @(negedge clock);
      w++;
    end
    tests++;
    if (w > 2) begin
      fails++;
      $display("FAIL tx_start_latency: got %0d clocks expected <=2", w);
      return;
    end
    fork
      begin
        for (int k = 0; k < 10 * CPB; k++) begin
          if (uart_txd !== fb[k / CPB]) bad[k / CPB] = 1'b1;
          @(negedge clock);
        end
      end
      begin
        repeat (40) @(negedge clock);
        bus_read(BASE + 64'd1, vmid);
      end
    join
    for (int i = 0; i < 10; i++) begin
      tests++;
      if (bad[i]) begin fails++; $display("FAIL tx_bit%0d byte %h: line wrong, expected %b", i, b, fb[i]); end
    end
    tests++;
    if (vmid[0] !== 1'b1) begin fails++; $display("FAIL tx_busy_mid: got %b expected 1", vmid[0]); end
    bus_read(BASE + 64'd1, v);
    tests++;
    if (v !== model_status(1'b0, 1'b0)) begin
      fails++; $display("FAIL tx_status_after: got %h expected %h", v, model_status(1'b0, 1'b0));
    end
  endtask

  task automatic test_fifo_full();
    logic [7:0]  exp_q[$];
    logic [7:0]  fifo_m[$];
    logic [7:0]  x;
    logic [63:0] v, e;
    int          w;
    longint      g;
    mon_bytes.delete();
    mon_start.delete();
    x = 8'($urandom);
    bus_write(BASE, x);
    exp_q.push_back(x);
    repeat (4) @(negedge clock);
    for (int i = 1; i <= 5; i++) begin
      bus_write(BASE, 8'(i));
      if (fifo_m.size() < 4) fifo_m.push_back(8'(i));
      bus_read(BASE + 64'd1, v);
      e = model_status(1'b1, fifo_m.size() == 4);
      tests++;
      if (v !== e) begin fails++; $display("FAIL fifo_status_w%0d: got %h expected %h", i, v, e); end
    end
    foreach (fifo_m[i]) exp_q.push_back(fifo_m[i]);
    w = 0;
    while (mon_bytes.size() < exp_q.size() && w < 1200) begin
      @(negedge clock);
      w++;
    end
    tests++;
    if (mon_bytes.size() != exp_q.size()) begin
      fails++; $display("FAIL fifo_frame_count: got %0d expected %0d", mon_bytes.size(), exp_q.size());
      return;
    end
    foreach (exp_q[i]) begin
      tests++;
      if (mon_bytes[i] !== exp_q[i]) begin fails++; $display("FAIL fifo_order%0d: got %h expected %h", i, mon_bytes[i], exp_q[i]); end
    end
    for (int i = 1; i < exp_q.size(); i++) begin
      g = longint'((mon_start[i] - mon_start[i - 1]) / 10);
      tests++;
      if (g < 10 * CPB || g > 10 * CPB + 1) begin fails++; $display("FAIL back_to_back%0d: got %0d clocks expected 160..161", i, g); end
    end
    repeat (20) @(negedge clock);
    bus_read(BASE + 64'd1, v);
    tests++;
    if (v !== model_status(1'b0, 1'b0)) begin fails++; $display("FAIL fifo_drained: got %h expected %h", v, model_status(1'b0, 1'b0)); end
  endtask

  task automatic test_loopback(input logic [7:0] b);
    logic [63:0] v;
    int          w;
    loop_en = 1'b1;
    bus_write(BASE, b);
    model_frame(b, 1'b1);
    w = 0;
    do begin
      bus_read(BASE + 64'd1, v);
      w++;
    end while (!(v[0] === 1'b0 && v[2] === 1'b1) && w < 150);
    tests++;
    if (v !== model_status(1'b0, 1'b0)) begin fails++; $display("FAIL loop_status %h: got %h expected %h", b, v, model_status(1'b0, 1'b0)); end
    bus_read(BASE + 64'd2, v);
    tests++;
    if (v !== {56'd0, m_byte}) begin fails++; $display("FAIL loop_rxdata: got %h expected %h", v, m_byte); end
    model_read_rx();
    bus_read(BASE + 64'd1, v);
    tests++;
    if (v !== model_status(1'b0, 1'b0)) begin fails++; $display("FAIL loop_cleared: got %h expected %h", v, model_status(1'b0, 1'b0)); end
    loop_en = 1'b0;
  endtask

  task automatic test_overrun(input logic [7:0] a, input logic [7:0] b);
    logic [63:0] v;
    send_frame(a, 1'b1);
    model_frame(a, 1'b1);
    send_frame(b, 1'b1);
    model_frame(b, 1'b1);
    bus_read(BASE + 64'd1, v);
    tests++;
    if (v !== model_status(1'b0, 1'b0)) begin fails++; $display("FAIL ovr_status: got %h expected %h", v, model_status(1'b0, 1'b0)); end
    bus_read(BASE + 64'd2, v);
    tests++;
    if (v !== {56'd0, m_byte}) begin fails++; $display("FAIL ovr_rxdata: got %h expected %h", v, m_byte); end
    model_read_rx();
    bus_read(BASE + 64'd1, v);
    tests++;
    if (v !== model_status(1'b0, 1'b0)) begin fails++; $display("FAIL ovr_cleared: got %h expected %h", v, model_status(1'b0, 1'b0)); end
  endtask

  task automatic test_glitch_framing();
    logic [63:0] v;
    logic [7:0]  c, d;
    rxd_drv = 1'b0;
    repeat (3) @(negedge clock);
    rxd_drv = 1'b1;
    repeat (40) @(negedge clock);
    bus_read(BASE + 64'd1, v);
    tests++;
    if (v !== model_status(1'b0, 1'b0)) begin fails++; $display("FAIL glitch_status: got %h expected %h", v, model_status(1'b0, 1'b0)); end
    c = 8'($urandom);
    send_frame(c, 1'b0);
    model_frame(c, 1'b0);
    repeat (20) @(negedge clock);
    bus_read(BASE + 64'd1, v);
    tests++;
    if (v !== model_status(1'b0, 1'b0)) begin fails++; $display("FAIL framing_status: got %h expected %h", v, model_status(1'b0, 1'b0)); end
    bus_read(BASE + 64'd2, v);
    tests++;
    if (v !== {56'd0, m_byte}) begin fails++; $display("FAIL framing_rxbyte: got %h expected %h", v, m_byte); end
    model_read_rx();
    d = 8'($urandom);
    send_frame(d, 1'b1);
    model_frame(d, 1'b1);
    bus_read(BASE + 64'd1, v);
    tests++;
    if (v !== model_status(1'b0, 1'b0)) begin fails++; $display("FAIL recover_status: got %h expected %h", v, model_status(1'b0, 1'b0)); end
    bus_read(BASE + 64'd2, v);
    tests++;
    if (v !== {56'd0, m_byte}) begin fails++; $display("FAIL recover_rxdata: got %h expected %h", v, m_byte); end
    model_read_rx();
  endtask

  task automatic test_reset_mid();
    logic [63:0] v;
    bus_write(BASE, 8'($urandom));
    repeat (8) @(negedge clock);
    tests++;
    if (uart_txd !== 1'b0) begin fails++; $display("FAIL mid_start_bit: got %b expected 0", uart_txd); end
    #2 reset_n = 1'b0;
    #1;
    tests++;
    if (uart_txd !== 1'b1) begin fails++; $display("FAIL mid_reset_txd: got %b expected 1", uart_txd); end
    model_read_rx();
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    bus_read(BASE + 64'd1, v);
    tests++;
    if (v !== 64'd0) begin fails++; $display("FAIL mid_reset_status: got %h expected 0", v); end
  endtask

  initial begin
    test_reset();
    test_single_tx(8'hA5);
    test_single_tx(8'($urandom));
    test_fifo_full();
    test_loopback(8'h3C);
    test_loopback(8'($urandom));
    test_overrun(8'h11, 8'h22);
    test_overrun(8'($urandom), 8'($urandom));
    test_glitch_framing();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
